// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg : shared widths, FSM encoding, length check helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package program_loader_pkg;
  localparam int ADDRESS_BITS = 11;
  localparam int DATA_BITS    = 16;
  localparam int MEM_SIZE     = 2 ** ADDRESS_BITS;
  localparam int LEN_BYTES    = 2;
  localparam int LEN_BITS     = 8 * LEN_BYTES;
  // One extra bit so the index can reach MEM_SIZE without wrapping
  localparam int CNT_BITS     = ADDRESS_BITS + 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_e;

  function automatic logic len_too_big(input logic [LEN_BITS-1:0] n);
    return {1'b0, n} > (LEN_BITS + 1)'(MEM_SIZE);
  endfunction
endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if : byte-stream input, program-memory write port, status
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface program_loader_if;
  logic                                  i_start;
  logic [7:0]                            i_rx_data;
  logic                                  i_rx_valid;
  logic                                  o_wr_en;
  logic [program_loader_pkg::ADDRESS_BITS-1:0] o_wr_addr;
  logic [program_loader_pkg::DATA_BITS-1:0]    o_wr_data;
  logic                                  o_busy;
  logic                                  o_done;
  logic                                  o_error;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_error
  );
endinterface

`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// program_loader_word_assembler : hi-byte latch and data-byte XOR accumulator
// Rev 1.0   (accumulator present with PROGRAM_LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 hi_en_i,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  input  logic                 acc_en_i,
  output logic [7:0]           xsum_o,
`endif
  input  logic [7:0]           byte_i,
  output logic [DATA_BITS-1:0] word_o
);
  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
    end else if (clear_i) begin
      hi_q <= '0;
    end else if (hi_en_i) begin
      hi_q <= byte_i;
    end
  end

  // Low byte is taken straight from the incoming byte; the top registers the word
  assign word_o = {hi_q, byte_i};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xsum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum_q <= '0;
    end else if (clear_i) begin
      xsum_q <= '0;
    end else if (acc_en_i) begin
      xsum_q <= xsum_q ^ byte_i;
    end
  end

  assign xsum_o = xsum_q;
`endif
endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader : assembles a length-prefixed byte stream into program words
// Rev 1.0   (optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module program_loader
  import program_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);
  state_e                  state_q;
  logic [7:0]              len_hi_q;
  logic [LEN_BITS-1:0]     len_q;
  logic [CNT_BITS-1:0]     idx_q;
  logic                    wr_en_q;
  logic [ADDRESS_BITS-1:0] wr_addr_q;
  logic [DATA_BITS-1:0]    wr_data_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;

  logic                    w_accept;
  logic                    w_hi_en;
  logic [DATA_BITS-1:0]    w_word;
  logic [LEN_BITS-1:0]     len_d;
  logic [CNT_BITS-1:0]     idx_d;

  assign w_accept = (state_q == S_IDLE) && bus.i_start;
  assign w_hi_en  = (state_q == S_DATA_HI) && bus.i_rx_valid;
  assign len_d    = {len_hi_q, bus.i_rx_data};
  assign idx_d    = idx_q + CNT_BITS'(1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic       w_acc_en;
  logic [7:0] w_xsum;

  assign w_acc_en = ((state_q == S_DATA_HI) || (state_q == S_DATA_LO)) && bus.i_rx_valid;
`endif

  program_loader_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_accept),
    .hi_en_i  (w_hi_en),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .acc_en_i (w_acc_en),
    .xsum_o   (w_xsum),
`endif
    .byte_i   (bus.i_rx_data),
    .word_o   (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (bus.i_rx_valid) begin
            len_hi_q <= bus.i_rx_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (bus.i_rx_valid) begin
            len_q <= len_d;
            if (len_too_big(len_d)) begin
              state_q <= S_ERROR;
            end else if (len_d == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (bus.i_rx_valid) begin
            state_q <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (bus.i_rx_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q[ADDRESS_BITS-1:0];
            wr_data_q <= w_word;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx_q <= idx_d;
          // A byte landing here means the sender outran the write cycle
          if (bus.i_rx_valid) begin
            state_q <= S_ERROR;
          end else if (LEN_BITS'(idx_d) == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_q <= S_CHECK;
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_DATA_HI;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (bus.i_rx_valid) begin
            state_q <= (bus.i_rx_data == w_xsum) ? S_DONE : S_ERROR;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          busy_q  <= 1'b0;
          error_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_error   = error_q;
endmodule

`default_nettype wire
